lsu: RTL and testbench

Parametrised multi-cycle load/store unit for the NPC core, replacing the single-cycle DPI memory stage. Accepts one load/store per transaction from the execute stage over a valid/ready handshake. Issues a word-aligned request on a req/gnt/rvalid memory bus with byte-lane write masks, then returns sign- or zero-extended load data (or a misalignment error) over a second valid/ready handshake to write-back. Supports RV32 and RV64 data widths.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 84 ++++++++
 rtl/lsu.sv | 159 +++++++++++++++
 tb/tb_lsu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the multi-cycle load/store unit.
// funct3 encodings follow the RISC-V load/store opcode space.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Number of byte-offset bits within one bus word.
    function automatic int off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational access checker and byte-lane steering for the LSU.
// Produces the legality flag, store lanes/data and the extended load result.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int OFF_W  = off_w(DATA_W),
    localparam int NB     = DATA_W / 8
) (
    input  logic              is_load,
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [NB-1:0]     wmask,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext
);

    localparam bit                IS64  = (DATA_W == 64);
    localparam logic [NB-1:0]     ONE_B = {{(NB-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ONE_D = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [1:0]        size;
    logic [2:0]        off3;
    logic              f3_ok;
    logic              misal;
    int                nbytes;
    int                nbits;
    logic [NB-1:0]     base_mask;
    logic [DATA_W-1:0] rd_sh;
    logic [DATA_W-1:0] keep;
    logic              fill;

    assign size = funct3[1:0];
    assign off3 = 3'(off);

    always_comb begin
        f3_ok = 1'b0;
        misal = 1'b0;
        if (is_load && !is_store) begin
            case (funct3)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_ok = 1'b1;
                F3_D, F3_WU:                    f3_ok = IS64;
                default:                        f3_ok = 1'b0;
            endcase
        end else if (is_store && !is_load) begin
            case (funct3)
                F3_B, F3_H, F3_W: f3_ok = 1'b1;
                F3_D:             f3_ok = IS64;
                default:          f3_ok = 1'b0;
            endcase
        end
        case (size)
            2'b01:   misal = off3[0];
            2'b10:   misal = |off3[1:0];
            2'b11:   misal = |off3;
            default: misal = 1'b0;
        endcase
        err = !f3_ok || misal;
    end

    always_comb begin
        nbytes    = 1 << size;
        nbits     = (8 * nbytes > DATA_W) ? DATA_W : 8 * nbytes;
        base_mask = (nbytes >= NB) ? '1 : (ONE_B << nbytes) - ONE_B;
        wmask     = is_store ? (base_mask << off) : '0;
        wdata_sh  = wdata << {off, 3'b000};
        rd_sh     = rdata >> {off, 3'b000};
        keep      = (nbits >= DATA_W) ? '1 : (ONE_D << nbits) - ONE_D;
        case (size)
            2'b00:   fill = rd_sh[7];
            2'b01:   fill = rd_sh[15];
            2'b10:   fill = rd_sh[31];
            default: fill = rd_sh[DATA_W-1];
        endcase
        // funct3[2] marks the unsigned variants.
        fill      = fill & !funct3[2];
        rdata_ext = (rd_sh & keep) | (fill ? ~keep : '0);
    end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: one transaction at a time from execute,
// issued on a req/gnt/rvalid bus and returned to write-back.
//
//   state | meaning
//   IDLE  | ready for a new request from execute
//   REQ   | bus request held stable until mem_gnt
//   WAIT  | granted, waiting for mem_rvalid
//   RESP  | result presented until out_ready
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_load,
    input  logic                in_store,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int OFF_W = off_w(DATA_W);
    localparam int NB    = DATA_W / 8;

    lsu_state_e state;
    lsu_state_e state_nxt;

    logic              load_q;
    logic              store_q;
    logic              err_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     wmask_q;
    logic [ADDR_W-1:0] addr_q;

    logic              sel_in;
    logic              a_load;
    logic              a_store;
    logic [2:0]        a_f3;
    logic [OFF_W-1:0]  a_off;
    logic              a_err;
    logic [NB-1:0]     a_wmask;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_rdata;

    // The checker sees the live request while idle and the latched one afterwards.
    assign sel_in  = (state == IDLE);
    assign a_load  = sel_in ? in_load   : load_q;
    assign a_store = sel_in ? in_store  : store_q;
    assign a_f3    = sel_in ? in_funct3 : f3_q;
    assign a_off   = sel_in ? in_addr[OFF_W-1:0] : off_q;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .is_load   (a_load),
        .is_store  (a_store),
        .funct3    (a_f3),
        .off       (a_off),
        .wdata     (in_wdata),
        .rdata     (mem_rdata),
        .err       (a_err),
        .wmask     (a_wmask),
        .wdata_sh  (a_wdata),
        .rdata_ext (a_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_req   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = a_err ? RESP : REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) state_nxt = RESP;
            end
            RESP: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q  <= 1'b0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            addr_q  <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                load_q  <= in_load;
                store_q <= in_store;
                f3_q    <= in_funct3;
                off_q   <= in_addr[OFF_W-1:0];
                err_q   <= a_err;
                rdata_q <= '0;
                // Bus-side registers only move for legal accesses.
                if (!a_err) begin
                    we_q    <= in_store;
                    addr_q  <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    wdata_q <= in_store ? a_wdata : '0;
                    wmask_q <= a_wmask;
                end
            end
            if (state == WAIT && mem_rvalid) begin
                rdata_q <= load_q ? a_rdata : '0;
            end
        end
    end

    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;
    assign out_rdata = rdata_q;
    assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: one 32-bit and one 64-bit instance share the
// stimulus; a select bit picks which instance each transaction targets.
module tb_lsu;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid32, in_valid64, in_load, in_store;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr;
    logic [63:0] in_wdata;
    logic        out_ready, mem_gnt, mem_rvalid;
    logic [63:0] mem_rdata;

    logic        in_ready32, out_valid32, out_err32, mem_req32, mem_we32;
    logic [31:0] out_rdata32, mem_addr32, mem_wdata32;
    logic [3:0]  mem_wmask32;
    logic        in_ready64, out_valid64, out_err64, mem_req64, mem_we64;
    logic [63:0] out_rdata64, mem_wdata64;
    logic [31:0] mem_addr64;
    logic [7:0]  mem_wmask64;

    lsu #(.DATA_W(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
        .in_wdata(in_wdata[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_rdata(out_rdata32), .out_err(out_err32), .mem_req(mem_req32), .mem_gnt(mem_gnt),
        .mem_we(mem_we32), .mem_addr(mem_addr32), .mem_wdata(mem_wdata32),
        .mem_wmask(mem_wmask32), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    lsu #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .in_load(in_load), .in_store(in_store), .in_funct3(in_funct3), .in_addr(in_addr),
        .in_wdata(in_wdata), .out_valid(out_valid64), .out_ready(out_ready),
        .out_rdata(out_rdata64), .out_err(out_err64), .mem_req(mem_req64), .mem_gnt(mem_gnt),
        .mem_we(mem_we64), .mem_addr(mem_addr64), .mem_wdata(mem_wdata64),
        .mem_wmask(mem_wmask64), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    bit          sel;
    logic        o_in_ready, o_out_valid, o_out_err, o_mem_req, o_mem_we;
    logic [63:0] o_out_rdata, o_mem_wdata;
    logic [31:0] o_mem_addr;
    logic [7:0]  o_mem_wmask;

    assign o_in_ready  = sel ? in_ready64  : in_ready32;
    assign o_out_valid = sel ? out_valid64 : out_valid32;
    assign o_out_err   = sel ? out_err64   : out_err32;
    assign o_mem_req   = sel ? mem_req64   : mem_req32;
    assign o_mem_we    = sel ? mem_we64    : mem_we32;
    assign o_out_rdata = sel ? out_rdata64 : {32'h0, out_rdata32};
    assign o_mem_wdata = sel ? mem_wdata64 : {32'h0, mem_wdata32};
    assign o_mem_addr  = sel ? mem_addr64  : mem_addr32;
    assign o_mem_wmask = sel ? mem_wmask64 : {4'h0, mem_wmask32};

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        bit          u64;
        bit          ld;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wd;
        logic [63:0] rd;
        logic [31:0] eaddr;
        logic [7:0]  emask;
        logic [63:0] ewd;
        logic [63:0] erd;
        bit          eerr;
    } vec_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

    bit          r_saw, r_we, r_stable, r_busy, r_rdy_after, r_tmo;
    logic [31:0] r_addr;
    logic [7:0]  r_mask;
    logic [63:0] r_wd, r_rd;
    logic        r_err;
    int          r_lat;

    // Drives one transaction and records what the DUT did; callers judge it.
    task automatic txn(input bit use64, input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                       input int gnt_dly, input int rdy_dly);
        int cyc;
        sel = use64;
        r_saw = 0; r_we = 0; r_addr = '0; r_mask = '0; r_wd = '0;
        r_stable = 1; r_busy = 1; r_tmo = 0;
        in_load = ld; in_store = st; in_funct3 = f3; in_addr = addr;
        in_wdata = wd; mem_rdata = rd;
        in_valid32 = !use64; in_valid64 = use64;
        @(negedge clk);
        in_valid32 = 0; in_valid64 = 0;
        cyc = 1;
        if (!o_out_valid) begin
            while (!o_mem_req && cyc < 10) begin @(negedge clk); cyc++; end
            if (o_mem_req) begin
                r_saw = 1; r_we = o_mem_we; r_addr = o_mem_addr;
                r_mask = o_mem_wmask; r_wd = o_mem_wdata;
                for (int i = 0; i <= gnt_dly; i++) begin
                    if (o_mem_req !== 1'b1 || o_mem_we !== r_we || o_mem_addr !== r_addr ||
                        o_mem_wmask !== r_mask || o_mem_wdata !== r_wd || o_out_valid !== 1'b0)
                        r_stable = 0;
                    if (o_in_ready !== 1'b0) r_busy = 0;
                    mem_gnt = (i == gnt_dly);
                    @(negedge clk); cyc++;
                end
                mem_gnt = 0; mem_rvalid = 1;
                @(negedge clk); cyc++;
                mem_rvalid = 0;
                while (!o_out_valid && cyc < 40) begin @(negedge clk); cyc++; end
            end
        end
        if (o_out_valid !== 1'b1) r_tmo = 1;
        r_lat = cyc; r_rd = o_out_rdata; r_err = o_out_err;
        for (int i = 0; i <= rdy_dly; i++) begin
            if (o_out_valid !== 1'b1 || o_out_rdata !== r_rd || o_out_err !== r_err) r_stable = 0;
            if (o_mem_req !== 1'b0) r_saw = 1;
            if (o_in_ready !== 1'b0) r_busy = 0;
            out_ready = (i == rdy_dly);
            @(negedge clk);
        end
        out_ready = 0;
        r_rdy_after = o_in_ready && !o_out_valid;
    endtask

    task automatic test_reset();
        rst_n = 0;
        in_valid32 = 0; in_valid64 = 0; in_load = 0; in_store = 0; in_funct3 = '0;
        in_addr = '0; in_wdata = '0; out_ready = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            nvec++; if (o_in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready[%0d] got %b exp 1", s, o_in_ready); end
            nvec++; if ({o_out_valid, o_out_err, o_mem_req, o_mem_we} !== 4'b0000) begin nerr++; $display("FAIL reset_flags[%0d] got %b exp 0000", s, {o_out_valid, o_out_err, o_mem_req, o_mem_we}); end
            nvec++; if (o_out_rdata !== 64'h0 || o_mem_addr !== 32'h0) begin nerr++; $display("FAIL reset_data[%0d] got %h/%h exp 0/0", s, o_out_rdata, o_mem_addr); end
            nvec++; if (o_mem_wdata !== 64'h0 || o_mem_wmask !== 8'h0) begin nerr++; $display("FAIL reset_wr[%0d] got %h/%h exp 0/0", s, o_mem_wdata, o_mem_wmask); end
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_load_lb();
        exp_t e;
        sb.push_back('{64'h0000_0000_FFFF_FF80, 1'b0});
        txn(0, 1, 0, F3_B, 32'h8000_0003, 64'h0, 64'h80FF_1234, 0, 0);
        e = sb.pop_front();
        nvec++; if (r_rd !== e.rdata) begin nerr++; $display("FAIL lb_rdata got %h exp %h", r_rd, e.rdata); end
        nvec++; if (r_err !== e.err) begin nerr++; $display("FAIL lb_err got %b exp %b", r_err, e.err); end
        nvec++; if (r_addr !== 32'h8000_0000) begin nerr++; $display("FAIL lb_addr got %h exp 80000000", r_addr); end
        nvec++; if (r_mask !== 8'h0 || r_we !== 1'b0) begin nerr++; $display("FAIL lb_mask got %h/%b exp 00/0", r_mask, r_we); end
        nvec++; if (r_lat !== 3) begin nerr++; $display("FAIL lb_latency got %0d exp 3", r_lat); end
        nvec++; if (r_tmo !== 1'b0 || r_rdy_after !== 1'b1) begin nerr++; $display("FAIL lb_handshake got tmo=%b rdy=%b exp 0/1", r_tmo, r_rdy_after); end
    endtask

    task automatic test_store_sh();
        exp_t e;
        sb.push_back('{64'h0, 1'b0});
        txn(0, 0, 1, F3_H, 32'h8000_0002, 64'h0000_ABCD, 64'hDEAD_BEEF, 0, 0);
        e = sb.pop_front();
        nvec++; if (r_we !== 1'b1) begin nerr++; $display("FAIL sh_we got %b exp 1", r_we); end
        nvec++; if (r_mask !== 8'b0000_1100) begin nerr++; $display("FAIL sh_mask got %b exp 00001100", r_mask); end
        nvec++; if (r_wd !== 64'hABCD_0000) begin nerr++; $display("FAIL sh_wdata got %h exp abcd0000", r_wd); end
        nvec++; if (r_rd !== e.rdata || r_err !== e.err) begin nerr++; $display("FAIL sh_result got %h/%b exp %h/%b", r_rd, r_err, e.rdata, e.err); end
    endtask

    task automatic test_misalign();
        vec_t v[7];
        exp_t e;
        v[0] = '{0, 1, 0, F3_W, 32'h8000_0001, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1};
        v[1] = '{0, 1, 0, F3_H, 32'h8000_0003, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1};
        v[2] = '{0, 1, 1, F3_B, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1};
        v[3] = '{0, 0, 0, F3_B, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1};
        v[4] = '{0, 0, 1, F3_D, 32'h8000_0000, 64'h1, 64'h0, 0, 0, 0, 64'h0, 1};
        v[5] = '{0, 1, 0, 3'b111, 32'h8000_0000, 64'h0, 64'h0, 0, 0, 0, 64'h0, 1};
        v[6] = '{0, 0, 1, F3_W, 32'h8000_0002, 64'h5, 64'h0, 0, 0, 0, 64'h0, 1};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{v[i].erd, v[i].eerr});
            txn(v[i].u64, v[i].ld, v[i].st, v[i].f3, v[i].addr, v[i].wd, 64'h8888_8888, 0, 1);
            e = sb.pop_front();
            nvec++; if (r_err !== e.err || r_rd !== e.rdata) begin nerr++; $display("FAIL misalign[%0d] result got %h/%b exp %h/%b", i, r_rd, r_err, e.rdata, e.err); end
            nvec++; if (r_lat !== 1) begin nerr++; $display("FAIL misalign[%0d] latency got %0d exp 1", i, r_lat); end
            nvec++; if (r_saw !== 1'b0) begin nerr++; $display("FAIL misalign[%0d] mem_req got %b exp 0", i, r_saw); end
        end
    endtask

    task automatic test_rv64();
        vec_t v[8];
        exp_t e;
        v[0] = '{1, 1, 0, F3_WU, 32'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 32'h8000_0000, 8'h00, 64'h0, 64'h0000_0000_8765_4321, 0};
        v[1] = '{1, 1, 0, F3_W,  32'h8000_0004, 64'h0, 64'h8765_4321_0000_0000, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_8765_4321, 0};
        v[2] = '{1, 1, 0, F3_D,  32'h8000_0008, 64'h0, 64'h0123_4567_89AB_CDEF, 32'h8000_0008, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 0};
        v[3] = '{1, 0, 1, F3_D,  32'h8000_0008, 64'h1122_3344_5566_7788, 64'h0, 32'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 0};
        v[4] = '{1, 0, 1, F3_W,  32'h8000_0004, 64'hDEAD_BEEF, 64'h0, 32'h8000_0000, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0, 0};
        v[5] = '{1, 1, 0, F3_H,  32'h8000_0006, 64'h0, 64'h8765_4321_0000_0000, 32'h8000_0000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8765, 0};
        v[6] = '{1, 1, 0, F3_D,  32'h8000_0004, 64'h0, 64'h0, 0, 0, 64'h0, 64'h0, 1};
        v[7] = '{0, 1, 0, F3_WU, 32'h8000_0004, 64'h0, 64'h8765_4321, 0, 0, 64'h0, 64'h0, 1};
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{v[i].erd, v[i].eerr});
            txn(v[i].u64, v[i].ld, v[i].st, v[i].f3, v[i].addr, v[i].wd, v[i].rd, 0, 0);
            e = sb.pop_front();
            nvec++; if (r_rd !== e.rdata || r_err !== e.err) begin nerr++; $display("FAIL rv64[%0d] result got %h/%b exp %h/%b", i, r_rd, r_err, e.rdata, e.err); end
            nvec++; if (r_saw !== !v[i].eerr) begin nerr++; $display("FAIL rv64[%0d] mem_req got %b exp %b", i, r_saw, !v[i].eerr); end
            if (!v[i].eerr) begin
                nvec++; if (r_addr !== v[i].eaddr || r_we !== v[i].st) begin nerr++; $display("FAIL rv64[%0d] addr got %h/%b exp %h/%b", i, r_addr, r_we, v[i].eaddr, v[i].st); end
                nvec++; if (r_mask !== v[i].emask || r_wd !== v[i].ewd) begin nerr++; $display("FAIL rv64[%0d] lanes got %h/%h exp %h/%h", i, r_mask, r_wd, v[i].emask, v[i].ewd); end
            end
        end
    endtask

    task automatic test_stall();
        exp_t e;
        sb.push_back('{64'h0, 1'b0});
        txn(0, 0, 1, F3_W, 32'h8000_0010, 64'h1122_3344, 64'h0, 4, 3);
        e = sb.pop_front();
        nvec++; if (r_stable !== 1'b1) begin nerr++; $display("FAIL stall_sw stable got %b exp 1", r_stable); end
        nvec++; if (r_busy !== 1'b1 || r_rdy_after !== 1'b1) begin nerr++; $display("FAIL stall_sw in_ready got busy=%b after=%b exp 1/1", r_busy, r_rdy_after); end
        nvec++; if (r_lat !== 7) begin nerr++; $display("FAIL stall_sw latency got %0d exp 7", r_lat); end
        nvec++; if (r_we !== 1'b1 || r_mask !== 8'h0F || r_wd !== 64'h1122_3344) begin nerr++; $display("FAIL stall_sw lanes got %b/%h/%h exp 1/0f/11223344", r_we, r_mask, r_wd); end
        nvec++; if (r_rd !== e.rdata || r_err !== e.err) begin nerr++; $display("FAIL stall_sw result got %h/%b exp %h/%b", r_rd, r_err, e.rdata, e.err); end
        sb.push_back('{64'hFFFF_80FF, 1'b0});
        txn(0, 1, 0, F3_H, 32'h8000_0002, 64'h0, 64'h80FF_1234, 4, 3);
        e = sb.pop_front();
        nvec++; if (r_stable !== 1'b1 || r_busy !== 1'b1) begin nerr++; $display("FAIL stall_lh hold got %b/%b exp 1/1", r_stable, r_busy); end
        nvec++; if (r_rd !== e.rdata || r_err !== e.err) begin nerr++; $display("FAIL stall_lh result got %h/%b exp %h/%b", r_rd, r_err, e.rdata, e.err); end
    endtask

    task automatic test_reset_abort();
        exp_t e;
        bit   quiet;
        sel = 0;
        in_load = 1; in_store = 0; in_funct3 = F3_B; in_addr = 32'h8000_0001;
        mem_rdata = 64'h80FF_1234; in_valid32 = 1;
        @(negedge clk);
        in_valid32 = 0; mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        nvec++; if ({o_in_ready, o_mem_req, o_out_valid} !== 3'b000) begin nerr++; $display("FAIL abort_wait got %b exp 000", {o_in_ready, o_mem_req, o_out_valid}); end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1; mem_rvalid = 1;
        @(negedge clk);
        mem_rvalid = 0; mem_gnt = 1;
        quiet = 1;
        for (int i = 0; i < 3; i++) begin
            if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1 || o_mem_req !== 1'b0) quiet = 0;
            @(negedge clk);
            mem_gnt = 0;
        end
        nvec++; if (quiet !== 1'b1) begin nerr++; $display("FAIL abort_quiet got %b exp 1", quiet); end
        sb.push_back('{64'h12, 1'b0});
        txn(0, 1, 0, F3_BU, 32'h8000_0001, 64'h0, 64'h80FF_1234, 0, 0);
        e = sb.pop_front();
        nvec++; if (r_rd !== e.rdata || r_err !== e.err) begin nerr++; $display("FAIL abort_lbu result got %h/%b exp %h/%b", r_rd, r_err, e.rdata, e.err); end
        nvec++; if (r_lat !== 3) begin nerr++; $display("FAIL abort_lbu latency got %0d exp 3", r_lat); end
    endtask

    task automatic test_back_to_back();
        vec_t v[7];
        exp_t e;
        v[0] = '{0, 1, 0, F3_HU, 32'h8000_0002, 64'h0, 64'h80FF_1234, 32'h8000_0000, 8'h0, 64'h0, 64'h0000_80FF, 0};
        v[1] = '{0, 1, 0, F3_H,  32'h8000_0002, 64'h0, 64'h80FF_1234, 32'h8000_0000, 8'h0, 64'h0, 64'hFFFF_80FF, 0};
        v[2] = '{0, 1, 0, F3_H,  32'h8000_0000, 64'h0, 64'h80FF_1234, 32'h8000_0000, 8'h0, 64'h0, 64'h0000_1234, 0};
        v[3] = '{0, 1, 0, F3_B,  32'h8000_0001, 64'h0, 64'h80FF_1234, 32'h8000_0000, 8'h0, 64'h0, 64'h0000_0012, 0};
        v[4] = '{0, 1, 0, F3_BU, 32'h8000_0003, 64'h0, 64'h80FF_1234, 32'h8000_0000, 8'h0, 64'h0, 64'h0000_0080, 0};
        v[5] = '{0, 1, 0, F3_W,  32'h8000_0004, 64'h0, 64'h80FF_1234, 32'h8000_0004, 8'h0, 64'h0, 64'h80FF_1234, 0};
        v[6] = '{0, 0, 1, F3_B,  32'h8000_0001, 64'hA5, 64'h0, 32'h8000_0000, 8'h02, 64'h0000_A500, 64'h0, 0};
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{v[i].erd, v[i].eerr});
            txn(v[i].u64, v[i].ld, v[i].st, v[i].f3, v[i].addr, v[i].wd, v[i].rd, 0, 0);
            e = sb.pop_front();
            nvec++; if (r_rd !== e.rdata || r_err !== e.err) begin nerr++; $display("FAIL b2b[%0d] result got %h/%b exp %h/%b", i, r_rd, r_err, e.rdata, e.err); end
            nvec++; if (r_addr !== v[i].eaddr || r_mask !== v[i].emask || r_wd !== v[i].ewd) begin nerr++; $display("FAIL b2b[%0d] bus got %h/%h/%h exp %h/%h/%h", i, r_addr, r_mask, r_wd, v[i].eaddr, v[i].emask, v[i].ewd); end
            nvec++; if (r_lat !== 3 || r_tmo !== 1'b0) begin nerr++; $display("FAIL b2b[%0d] latency got %0d/%b exp 3/0", i, r_lat, r_tmo); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_lb();
        test_store_sh();
        test_misalign();
        test_rv64();
        test_stall();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
